// File: rtl/seven_seg_capture.sv
// seven_seg_capture: rebuilds eight hex digits from a multiplexed seven-segment bus with dwell filtering
module seven_seg_capture #(
  parameter int SETTLE         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg,
  input  logic [7:0]  seg_sel,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [7:0]  dp,
  output logic        frame_done,
  output logic        sel_error
);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [7:0] s_seg, s_sel, p_seg, p_sel, cnt, nc, seen, nseen;
  logic       captured, same, cap, hit;
  logic [3:0] val;
  always_comb begin
    same  = {s_seg, s_sel} == {p_seg, p_sel};
    nc    = !same ? 8'd1 : (cnt == 8'(SETTLE)) ? cnt : cnt + 8'd1;
    cap   = (nc == 8'(SETTLE)) && (!same || !captured);
    nseen = seen | s_sel;
    hit   = 1'b0;
    val   = 4'd0;
    for (int i = 0; i < 16; i++)
      if (s_seg[6:0] == SEG_LUT[i]) begin
        hit = 1'b1;
        val = 4'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg       <= '0;
      s_sel       <= '0;
      p_seg       <= '0;
      p_sel       <= '0;
      cnt         <= '0;
      captured    <= 1'b0;
      seen        <= '0;
      digits      <= '0;
      digit_valid <= '0;
      dp          <= '0;
      frame_done  <= 1'b0;
      sel_error   <= 1'b0;
    end else begin
      s_seg      <= seg ^ {8{SEG_ACTIVE_LOW}};
      s_sel      <= seg_sel ^ {8{SEL_ACTIVE_LOW}};
      p_seg      <= s_seg;
      p_sel      <= s_sel;
      cnt        <= nc;
      captured   <= cap | (same & captured);
      frame_done <= 1'b0;
      sel_error  <= cap && !$onehot0(s_sel);
      if (cap && $onehot(s_sel)) begin
        for (int i = 0; i < 8; i++)
          if (s_sel[i]) begin
            digits[4*i +: 4] <= hit ? val : 4'd0;
            digit_valid[i]   <= hit;
            dp[i]            <= s_seg[7];
          end
        frame_done <= &nseen;
        seen       <= &nseen ? 8'h00 : nseen;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: random and directed scoreboard check of two seven_seg_capture configurations
module tb_seven_seg_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg = 8'hFF, seg_sel = 8'hFF;
  logic [31:0] dig0, dig1;
  logic [7:0]  val0, val1, dp0, dp1;
  logic        fd0, fd1, se0, se1;
  int n_vec = 0, n_err = 0, fd_cnt = 0, se_cnt = 0;

  seven_seg_capture #(.SETTLE(4), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst), .seg(seg), .seg_sel(seg_sel), .digits(dig0),
    .digit_valid(val0), .dp(dp0), .frame_done(fd0), .sel_error(se0));
  seven_seg_capture #(.SETTLE(1), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .seg(seg), .seg_sel(seg_sel), .digits(dig1),
    .digit_valid(val1), .dp(dp1), .frame_done(fd1), .sel_error(se1));

  always #5 clk = ~clk;

  logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          settle [2] = '{4, 1};
  bit          seg_al [2] = '{1'b1, 1'b0};
  bit          sel_al [2] = '{1'b1, 1'b1};
  logic [15:0] hist [2][512];
  int          hn [2];
  logic [31:0] e_dig [2];
  logic [7:0]  e_val [2], e_dp [2], e_seen [2];
  bit          e_fd [2], e_se [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // A digit is taken when the run of identical samples since reset first reaches the dwell length.
  task automatic step(input int u, input logic [7:0] sg, input logic [7:0] sl, input bit r);
    logic [15:0] last;
    logic [7:0]  s_seg, s_sel;
    logic [3:0]  v;
    bit          h;
    int          run, n;
    e_fd[u] = 0;
    e_se[u] = 0;
    if (r) begin
      hn[u] = 1;
      hist[u][0] = '0;
      e_dig[u] = '0; e_val[u] = '0; e_dp[u] = '0; e_seen[u] = '0;
    end else begin
      last = hist[u][(hn[u]-1) % 512];
      run = 0;
      for (int j = hn[u]-1; j >= 0 && run <= settle[u] && hist[u][j % 512] == last; j--) run++;
      if (run == settle[u]) begin
        s_seg = last[15:8];
        s_sel = last[7:0];
        if ($countones(s_sel) == 1) begin
          n = 0;
          for (int i = 0; i < 8; i++) if (s_sel[i]) n = i;
          h = 0; v = 0;
          for (int i = 0; i < 16; i++) if (lut[i] == s_seg[6:0]) begin h = 1; v = 4'(i); end
          e_dig[u][4*n +: 4] = v;
          e_val[u][n] = h;
          e_dp[u][n] = s_seg[7];
          e_seen[u][n] = 1'b1;
          if (e_seen[u] == 8'hFF) begin
            e_fd[u] = 1;
            e_seen[u] = '0;
          end
        end else if (s_sel != 0) e_se[u] = 1;
      end
      hist[u][hn[u] % 512] = {sg ^ {8{seg_al[u]}}, sl ^ {8{sel_al[u]}}};
      hn[u]++;
    end
  endtask

  task automatic cyc(input logic [7:0] sg, input logic [7:0] sl, input bit r);
    seg = sg; seg_sel = sl; rst = r;
    @(posedge clk);
    step(0, sg, sl, r);
    step(1, sg, sl, r);
    #1;
    check("u0_digits", dig0, e_dig[0]);
    check("u0_valid", {24'd0, val0}, {24'd0, e_val[0]});
    check("u0_dp", {24'd0, dp0}, {24'd0, e_dp[0]});
    check("u0_frame_done", {31'd0, fd0}, {31'd0, e_fd[0]});
    check("u0_sel_error", {31'd0, se0}, {31'd0, e_se[0]});
    check("u1_digits", dig1, e_dig[1]);
    check("u1_valid", {24'd0, val1}, {24'd0, e_val[1]});
    check("u1_dp", {24'd0, dp1}, {24'd0, e_dp[1]});
    check("u1_frame_done", {31'd0, fd1}, {31'd0, e_fd[1]});
    check("u1_sel_error", {31'd0, se1}, {31'd0, e_se[1]});
    fd_cnt += int'(fd0);
    se_cnt += int'(se0);
  endtask

  // Values are given high-true; the bus is driven low-true.
  task automatic hold(input logic [7:0] hs, input logic [7:0] hl, input int n);
    for (int i = 0; i < n; i++) cyc(~hs, ~hl, 1'b0);
  endtask

  initial begin
    logic [7:0] hs, hl;
    cyc(8'hFF, 8'hFF, 1'b1);
    cyc(8'hFF, 8'hFF, 1'b1);
    hold(8'h06, 8'h01, 4);
    check("t1_before", dig0, 32'd0);
    hold(8'h06, 8'h01, 2);
    check("t1_digit", dig0, 32'd1);
    check("t1_valid", {24'd0, val0}, 32'h01);
    hold(8'h4F, 8'h02, 3);
    hold(8'h00, 8'h00, 6);
    check("t2_glitch_valid", {31'd0, val0[1]}, 32'd0);
    fd_cnt = 0;
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < 8; d++) hold({d == 3, lut[d]}, 8'(1 << d), 8);
    check("t3_digits", dig0, 32'h76543210);
    check("t3_valid", {24'd0, val0}, 32'hFF);
    check("t3_dp", {24'd0, dp0}, 32'h08);
    check("t3_pulses", fd_cnt, 2);
    hold(8'h00, 8'h20, 8);
    check("t4_blank", {27'd0, val0[5], dig0[23:20]}, 32'd0);
    hold(8'h80, 8'h20, 8);
    check("t4_dp_only", {30'd0, dp0[5], val0[5]}, 32'h2);
    se_cnt = 0;
    hold(8'h06, 8'h03, 10);
    check("t5_sel_error", se_cnt, 1);
    hold(8'h77, 8'h10, 2);
    cyc(~8'h77, ~8'h10, 1'b1);
    check("t6_reset", {dig0[31:8] | dig0[7:0], val0}, 32'd0);
    hold(8'h77, 8'h10, 4);
    check("t6_early", {28'd0, dig0[19:16]}, 32'd0);
    hold(8'h77, 8'h10, 1);
    check("t6_digit", {28'd0, dig0[19:16]}, 32'hA);
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0:       hl = 8'h00;
        1:       hl = 8'($urandom_range(0, 255)) | 8'h81;
        default: hl = 8'(1 << $urandom_range(0, 7));
      endcase
      hs = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                        : {1'($urandom_range(0, 1)), lut[$urandom_range(0, 15)]};
      if ($urandom_range(0, 49) == 0) cyc(~hs, ~hl, 1'b1);
      else hold(hs, hl, $urandom_range(1, 9));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display bus (seg/seg_sel).
- Samples a time-multiplexed seg/seg_sel stream and rebuilds the eight displayed digits as hex nibbles with per-digit valid and decimal-point flags.
- Used as an on-board loopback checker and for the bench-side display scoreboard.
- Filters ghosting during digit switch-over by requiring a stable dwell before each capture.

Parameters:
- SETTLE, 4: consecutive identical samples required before a digit is captured (range 1..255).
- SEG_ACTIVE_LOW, 1: 1 = segment lines are low-true; 0 = high-true.
- SEL_ACTIVE_LOW, 1: 1 = digit selects are low-true; 0 = high-true.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- seg  input  8  segment bus; bit0=a … bit6=g, bit7=dp
- seg_sel  input  8  digit select; bit n = digit n
- digits  output  32  digits[4n+3:4n] = decoded nibble of digit n
- digit_valid  output  8  bit n = last capture of digit n decoded to 0–F
- dp  output  8  bit n = decimal point of last capture of digit n
- frame_done  output  1  one-cycle pulse when all 8 digits captured since last pulse
- sel_error  output  1  one-cycle pulse on each stable non-one-hot select

Behaviour:
- Reset, when rst=1 at a clk edge:
  - digits, digit_valid, dp, frame_done and sel_error all = 0.
  - Sample registers, dwell counter, captured flag and seen mask all cleared.
  - Reset mid-dwell discards the partial dwell; a dwell in progress must restart after reset.
- Input stage:
  - seg and seg_sel are registered once (s_seg, s_sel).
  - Polarity is normalised to high-true per the parameters.
- Dwell counter:
  - If {s_seg,s_sel} equals its previous-cycle value, cnt increments, saturating at SETTLE.
  - Otherwise cnt=1 and captured=0.
- Capture:
  - Occurs on the edge where cnt reaches SETTLE with captured=0; then captured=1.
  - Exactly one capture per dwell, however long the dwell is held.
- Latency: outputs update 1+SETTLE edges after the first edge at which new seg/seg_sel is presented.
- At capture, one-hot s_sel selecting digit n:
  - dp[n] = s_seg[7].
  - s_seg[6:0] is decoded via the table below.
  - On a match: digits nibble n = value and digit_valid[n] = 1.
  - On no match (including blank 00): nibble n = 0 and digit_valid[n] = 0.
  - seen[n] is set.
- At capture with s_sel zero or multi-hot:
  - No digit state changes.
  - sel_error pulses for 1 cycle when s_sel has two or more bits set.
  - All-zero s_sel (blanking interval) is silently ignored.
- Decode table, high-true gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Frame completion:
  - When the capture edge makes seen == FF, frame_done=1 for that one cycle and seen clears to 00 on the same edge.
  - Re-capturing an already-seen digit updates its outputs but does not advance the frame.
- SETTLE=1: every sample that differs from the previous one is captured on the next edge.

Test Plan:
1. SETTLE=4, active-low. After reset, hold seg=~8'h06, seg_sel=~8'h01 for 6 cycles -> digits[3:0]=1, digit_valid=01, dp=00 on cycle 5; outputs all 0 before that.
2. Glitch reject: hold seg_sel=~8'h02 with seg=~8'h4F for only 3 cycles, then switch -> no update to digit 1; digit_valid[1] stays 0.
3. Full frame: scan digits 0..7 with values 0..7 and dp on digit 3, 8-cycle dwell each -> digits=32'h76543210, digit_valid=FF, dp=08, one frame_done pulse after digit 7 capture; repeating the scan gives a second single pulse.
4. Invalid patterns:
   - seg=~8'h00 (blank) on digit 5 -> digit_valid[5]=0, nibble 5=0.
   - seg=~8'h80 on digit 5 -> dp[5]=1, digit_valid[5]=0.
5. Select error: seg_sel=~8'h03 held 10 cycles -> exactly one sel_error pulse, no digit change.
6. Reset mid-dwell: assert rst at cycle 2 of a digit-4 dwell with value A, then release -> outputs 0; digit 4 captures A only after 4 further identical samples.
